// File: rtl/game_board_state_if.sv
// Cell write port between game logic (master) and board storage (slave).
interface game_board_state_if #(
  parameter int unsigned CELL_W = 5
);
  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_row;
  logic [3:0]        wr_col;
  logic [CELL_W-1:0] wr_data;
  logic              wr_err;

  modport master (
    output wr_valid, wr_row, wr_col, wr_data,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_data,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/game_board_state.sv
// Board storage and game-on status: clear sweep on start, valid/ready cell
// writes during play, registered single-cell read port.
module game_board_state #(
  parameter int unsigned      CELL_W    = 5,
  parameter logic [CELL_W-1:0] CLEAR_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_game,
  input  logic                            end_game,
  input  logic [2:0]                      size_sel,
  game_board_state_if.slave               wr,
  input  logic [3:0]                      rd_row,
  input  logic [3:0]                      rd_col,
  output logic [CELL_W-1:0]               rd_data,
  output logic                            is_game_on,
  output logic [2:0]                      board_size,
  output logic [15:0][15:0][CELL_W-1:0]   board,
  output logic                            clear_done
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned N_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = 8'hFF;
  localparam logic [2:0]       RST_SIZE = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] clr_idx;
  logic             wr_err_q;

  logic             wr_ready_c;
  logic             wr_fire_c;
  logic             wr_in_range_c;
  logic             clr_en_c;
  logic             sweep_last_c;
  logic [N_W-1:0]   n_c;

  assign wr.wr_ready = wr_ready_c;
  assign wr.wr_err   = wr_err_q;

  // Active edge length of the current board: 2*(board_size+1), 2..16.
  assign n_c = N_W'({board_size, 1'b0}) + N_W'(2);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; start_game takes priority everywhere, end_game is ignored mid-sweep.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_game) next_state = S_CLEAR;
      end
      S_CLEAR: begin
        if (start_game)              next_state = S_CLEAR;
        else if (clr_idx == LAST_IDX) next_state = S_RUN;
      end
      S_RUN: begin
        if (start_game)    next_state = S_CLEAR;
        else if (end_game) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath controls decoded from state and inputs.
  always_comb begin
    wr_ready_c    = 1'b0;
    clr_en_c      = 1'b0;
    sweep_last_c  = 1'b0;
    wr_in_range_c = (N_W'(wr.wr_row) < n_c) && (N_W'(wr.wr_col) < n_c);
    if (state == S_RUN)   wr_ready_c = !start_game;
    if (state == S_CLEAR) clr_en_c   = !start_game;
    if (clr_en_c && (clr_idx == LAST_IDX)) sweep_last_c = 1'b1;
    wr_fire_c = wr.wr_valid && wr_ready_c;
  end

  // Sweep index, latched size and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx    <= '0;
      board_size <= RST_SIZE;
      is_game_on <= 1'b0;
      clear_done <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      if (start_game) begin
        board_size <= size_sel;
        clr_idx    <= '0;
      end else if (clr_en_c) begin
        clr_idx    <= clr_idx + IDX_W'(1);
      end
      is_game_on <= (next_state == S_RUN);
      clear_done <= sweep_last_c;
      wr_err_q   <= wr_fire_c && !wr_in_range_c;
    end
  end

  // Cell storage: sweep clears one cell per cycle, otherwise in-range writes land.
  always_ff @(posedge clk) begin
    if (rst) begin
      board <= {256{CLEAR_VAL}};
    end else if (clr_en_c) begin
      board[clr_idx[7:4]][clr_idx[3:0]] <= CLEAR_VAL;
    end else if (wr_fire_c && wr_in_range_c) begin
      board[wr.wr_row][wr.wr_col] <= wr.wr_data;
    end
  end

  // Registered read; a same-cycle write is seen on the following read.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= board[rd_row][rd_col];
  end

endmodule

// File: tb/tb_game_board_state.sv
// Directed bench for game_board_state.
module tb_game_board_state;

  localparam int unsigned CELL_W = 5;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start_game;
  logic                          end_game;
  logic [2:0]                    size_sel;
  logic [3:0]                    rd_row;
  logic [3:0]                    rd_col;
  logic [CELL_W-1:0]             rd_data;
  logic                          is_game_on;
  logic [2:0]                    board_size;
  logic [15:0][15:0][CELL_W-1:0] board;
  logic                          clear_done;

  int n_checks = 0;
  int n_pass   = 0;

  game_board_state_if #(.CELL_W(CELL_W)) bus ();

  game_board_state #(.CELL_W(CELL_W), .CLEAR_VAL(5'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_game (start_game),
    .end_game   (end_game),
    .size_sel   (size_sel),
    .wr         (bus),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .is_game_on (is_game_on),
    .board_size (board_size),
    .board      (board),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run edges until clear_done, bounded; cnt = edges after the start edge, early = is_game_on seen before.
  task automatic wait_clear(output int cnt, output int early);
    cnt   = 0;
    early = 0;
    while (!clear_done && cnt < 400) begin
      tick();
      cnt++;
      if (!clear_done && is_game_on) early++;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; start_game = 0; end_game = 0; size_sel = 0;
    bus.wr_valid = 0; bus.wr_row = 0; bus.wr_col = 0; bus.wr_data = 0;
    rd_row = 0; rd_col = 0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (is_game_on !== 1'b0) $display("FAIL reset_game_on got=%0b exp=0", is_game_on); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL reset_wr_ready got=%0b exp=0", bus.wr_ready); else n_pass++;
    n_checks++; if (board_size !== 3'd7) $display("FAIL reset_board_size got=%0d exp=7", board_size); else n_pass++;
    n_checks++; if (rd_data !== 5'd0) $display("FAIL reset_rd_data got=%0d exp=0", rd_data); else n_pass++;
    n_checks++; if (clear_done !== 1'b0 || bus.wr_err !== 1'b0)
      $display("FAIL reset_pulses got clear_done=%0b wr_err=%0b exp=0,0", clear_done, bus.wr_err); else n_pass++;
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (board[r][c] !== 5'd0) bad++;
    n_checks++; if (bad != 0) $display("FAIL reset_cells nonzero_cells=%0d exp=0", bad); else n_pass++;
  endtask

  task automatic test_start_sweep();
    int cnt, early;
    size_sel = 3'd3; start_game = 1;
    tick();
    start_game = 0;
    // end_game mid-sweep must be ignored
    tick(); end_game = 1; tick(); end_game = 0;
    wait_clear(cnt, early);
    cnt = cnt + 2;
    n_checks++; if (cnt != 256) $display("FAIL sweep_latency got=%0d exp=256", cnt); else n_pass++;
    n_checks++; if (early != 0) $display("FAIL sweep_early_game_on got=%0d exp=0", early); else n_pass++;
    n_checks++; if (is_game_on !== 1'b1) $display("FAIL sweep_game_on got=%0b exp=1", is_game_on); else n_pass++;
    n_checks++; if (board_size !== 3'd3) $display("FAIL sweep_board_size got=%0d exp=3", board_size); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL run_wr_ready got=%0b exp=1", bus.wr_ready); else n_pass++;
    tick();
    n_checks++; if (clear_done !== 1'b0) $display("FAIL clear_done_width got=%0b exp=0", clear_done); else n_pass++;
  endtask

  task automatic test_write_in_range();
    bus.wr_valid = 1; bus.wr_row = 4'd2; bus.wr_col = 4'd5; bus.wr_data = 5'd17;
    rd_row = 4'd2; rd_col = 4'd5;
    tick();
    n_checks++; if (board[2][5] !== 5'd17) $display("FAIL wr_cell got=%0d exp=17", board[2][5]); else n_pass++;
    n_checks++; if (rd_data !== 5'd0) $display("FAIL rd_same_cycle_old got=%0d exp=0", rd_data); else n_pass++;
    n_checks++; if (bus.wr_err !== 1'b0) $display("FAIL wr_in_range_err got=%0b exp=0", bus.wr_err); else n_pass++;
    // corner cell of an 8x8 board is still in range
    bus.wr_row = 4'd7; bus.wr_col = 4'd7; bus.wr_data = 5'd5;
    tick();
    bus.wr_valid = 0;
    n_checks++; if (rd_data !== 5'd17) $display("FAIL rd_after_write got=%0d exp=17", rd_data); else n_pass++;
    n_checks++; if (board[7][7] !== 5'd5) $display("FAIL wr_corner got=%0d exp=5", board[7][7]); else n_pass++;
  endtask

  task automatic test_write_out_of_range();
    bus.wr_valid = 1; bus.wr_row = 4'd9; bus.wr_col = 4'd0; bus.wr_data = 5'd4;
    tick();
    bus.wr_row = 4'd0; bus.wr_col = 4'd8; bus.wr_data = 5'd6;
    n_checks++; if (bus.wr_err !== 1'b1) $display("FAIL oor_row_err got=%0b exp=1", bus.wr_err); else n_pass++;
    n_checks++; if (board[9][0] !== 5'd0) $display("FAIL oor_row_cell got=%0d exp=0", board[9][0]); else n_pass++;
    tick();
    bus.wr_valid = 0;
    n_checks++; if (bus.wr_err !== 1'b1) $display("FAIL oor_col_err got=%0b exp=1", bus.wr_err); else n_pass++;
    n_checks++; if (board[0][8] !== 5'd0) $display("FAIL oor_col_cell got=%0d exp=0", board[0][8]); else n_pass++;
    rd_row = 4'd9; rd_col = 4'd0;
    tick();
    n_checks++; if (bus.wr_err !== 1'b0) $display("FAIL oor_err_width got=%0b exp=0", bus.wr_err); else n_pass++;
    n_checks++; if (rd_data !== 5'd0) $display("FAIL rd_outside_n got=%0d exp=0", rd_data); else n_pass++;
  endtask

  task automatic test_write_end_game();
    int cnt, early;
    bus.wr_valid = 1; bus.wr_row = 4'd1; bus.wr_col = 4'd1; bus.wr_data = 5'd9;
    end_game = 1;
    tick();
    end_game = 0;
    n_checks++; if (board[1][1] !== 5'd9) $display("FAIL end_write_cell got=%0d exp=9", board[1][1]); else n_pass++;
    n_checks++; if (is_game_on !== 1'b0) $display("FAIL end_game_on got=%0b exp=0", is_game_on); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL end_wr_ready got=%0b exp=0", bus.wr_ready); else n_pass++;
    // write attempt while idle has no effect
    bus.wr_data = 5'd2;
    tick();
    bus.wr_valid = 0;
    n_checks++; if (board[1][1] !== 5'd9) $display("FAIL idle_write_cell got=%0d exp=9", board[1][1]); else n_pass++;
    n_checks++; if (board_size !== 3'd3) $display("FAIL idle_board_size got=%0d exp=3", board_size); else n_pass++;
    size_sel = 3'd7; start_game = 1;
    tick();
    start_game = 0;
    wait_clear(cnt, early);
    n_checks++; if (cnt != 256) $display("FAIL restart_latency got=%0d exp=256", cnt); else n_pass++;
    n_checks++; if (board[1][1] !== 5'd0 || board[2][5] !== 5'd0 || board[7][7] !== 5'd0)
      $display("FAIL restart_cleared got=%0d,%0d,%0d exp=0,0,0", board[1][1], board[2][5], board[7][7]); else n_pass++;
    // N=16: the far corner is writable
    bus.wr_valid = 1; bus.wr_row = 4'd15; bus.wr_col = 4'd15; bus.wr_data = 5'd31;
    tick();
    bus.wr_valid = 0;
    n_checks++; if (board[15][15] !== 5'd31 || bus.wr_err !== 1'b0)
      $display("FAIL n16_corner got=%0d err=%0b exp=31 err=0", board[15][15], bus.wr_err); else n_pass++;
  endtask

  task automatic test_restart_and_reset();
    int cnt, early;
    // start + end in the same RUN cycle: start wins
    size_sel = 3'd1; start_game = 1; end_game = 1;
    tick();
    start_game = 0; end_game = 0;
    for (int i = 0; i < 100; i++) tick();
    n_checks++; if (board[15][15] !== 5'd31) $display("FAIL sweep_partial got=%0d exp=31", board[15][15]); else n_pass++;
    size_sel = 3'd2; start_game = 1;
    tick();
    start_game = 0;
    wait_clear(cnt, early);
    n_checks++; if (cnt != 256) $display("FAIL sweep_restart_latency got=%0d exp=256", cnt); else n_pass++;
    n_checks++; if (board_size !== 3'd2 || board[15][15] !== 5'd0)
      $display("FAIL sweep_restart_state got size=%0d cell=%0d exp size=2 cell=0", board_size, board[15][15]); else n_pass++;
    // N=6: (5,5) in range, index 85 survives a 50-cell partial sweep
    bus.wr_valid = 1; bus.wr_row = 4'd5; bus.wr_col = 4'd5; bus.wr_data = 5'd21;
    tick();
    bus.wr_valid = 0;
    size_sel = 3'd4; start_game = 1;
    tick();
    start_game = 0;
    for (int i = 0; i < 50; i++) tick();
    n_checks++; if (board[5][5] !== 5'd21 || board[3][1] !== 5'd0)
      $display("FAIL mid_sweep_cells got=%0d,%0d exp=21,0", board[5][5], board[3][1]); else n_pass++;
    rd_row = 4'd5; rd_col = 4'd5;
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (board[5][5] !== 5'd0 || board_size !== 3'd7 || is_game_on !== 1'b0 || rd_data !== 5'd0)
      $display("FAIL rst_mid_sweep got cell=%0d size=%0d on=%0b rd=%0d exp 0,7,0,0",
               board[5][5], board_size, is_game_on, rd_data); else n_pass++;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (clear_done || is_game_on) cnt++;
    end
    n_checks++; if (cnt != 0 || bus.wr_ready !== 1'b0)
      $display("FAIL rst_stays_idle got active_cycles=%0d ready=%0b exp 0,0", cnt, bus.wr_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start_sweep();
    test_write_in_range();
    test_write_out_of_range();
    test_write_end_game();
    test_restart_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
